// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
`else
  // Producer/consumer side.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial W-bit adder built from one full-adder slice
// (two half-adder stages plus an OR) reused over W cycles, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic s;
    logic c;
  } ha_t;

  // Half-adder cell: the only arithmetic primitive in the datapath.
  function automatic ha_t ha(input logic x, input logic y);
    ha_t r;
    r.s = x ^ y;
    r.c = x & y;
    return r;
  endfunction

  state_t        state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  sa_q;
  logic [W-1:0]  sb_q;
  logic [W-1:0]  r_q;
  logic          carry_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  s_q;
  logic          cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic          ovf_q;
`endif

  ha_t           h1;
  ha_t           h2;
  logic          sum_bit;
  logic          carry_d;
  logic [W-1:0]  r_d;
  logic          last_bit;

  // Full-adder slice for the current bit plus the shifted result word.
  always_comb begin
    h1       = ha(sa_q[0], sb_q[0]);
    h2       = ha(h1.s, carry_q);
    sum_bit  = h2.s;
    carry_d  = h1.c | h2.c;
    // New bit enters at the MSB; after W shifts bit 0 of the sum sits at r[0].
    r_d      = W'({sum_bit, r_q} >> 1);
    last_bit = (cnt_q == CW'(W - 1));
  end

  // Control FSM and all state registers; handshake outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sa_q        <= '0;
      sb_q        <= '0;
      r_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sa_q       <= bus.a;
            sb_q       <= bus.b;
            carry_q    <= bus.cin;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          r_q     <= r_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            // Publish only here so s/cout stay stable through DONE and IDLE.
            s_q         <= r_d;
            cout_q      <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q is the carry into the MSB on the final bit.
            ovf_q       <= carry_q ^ carry_d;
`endif
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Return to IDLE only; a new acceptance needs one more edge.
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (W=8 and W=1 instances).
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.W(W)) bus ();
  serial_adder_if #(.W(1)) bus1 ();

  serial_adder #(.W(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
  serial_adder #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic read_ovf();
`ifdef SERIAL_ADDER_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: exact sum a+b+cin as a (W+1)-bit integer.
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] t;
    t = a + b + c;
    return t;
  endfunction

  // Reference: signed result outside the representable W-bit range.
  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int sv;
    sv = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (sv > (2 ** (W - 1)) - 1) || (sv < -(2 ** (W - 1)));
  endfunction

  // Present operands for one edge, then wait (bounded) for out_valid.
  // lat counts edges after the acceptance edge; 40 means it never arrived.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] so, output logic co, output logic oo, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    so = bus.s; co = bus.cout; oo = read_ovf();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.s !== '0 || bus.cout !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b s=%h cout=%b, required 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.s, bus.cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf: ovf=%b, required 0", bus.ovf);
    end
`endif
    rst = 1'b0;
    $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{8'h3C, 8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic [W-1:0] tb[5] = '{8'h05, 8'h01, 8'hFF, 8'h01, 8'h80};
    logic         tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] ts[5] = '{8'h41, 8'h00, 8'hFF, 8'h80, 8'h00};
    logic         tco[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         tov[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] so;
    logic         co, oo;
    int           lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], so, co, oo, lat);
      $display("directed: a=%h b=%h cin=%b -> s=%h cout=%b ovf=%b lat=%0d", ta[i], tb[i], tc[i], so, co, oo, lat);
      checks++;
      if (lat !== W) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, W);
      end
      checks++;
      if (so !== ts[i] || co !== tco[i]) begin
        failures++;
        $display("FAIL directed_sum[%0d]: got s=%h cout=%b, required s=%h cout=%b", i, so, co, ts[i], tco[i]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (oo !== tov[i]) begin
        failures++;
        $display("FAIL directed_ovf[%0d]: got %b, required %b", i, oo, tov[i]);
      end
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL directed_handshake[%0d]: out_valid=%b in_ready=%b, required 0 1", i, bus.out_valid, bus.in_ready);
      end
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, so;
    logic         c, co, oo;
    logic [W:0]   exp;
    int           lat;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      exp = model_sum(a, b, c);
      run_op(a, b, c, so, co, oo, lat);
      $display("random: a=%h b=%h cin=%b -> s=%h cout=%b ovf=%b lat=%0d", a, b, c, so, co, oo, lat);
      checks++;
      if (lat !== W || {co, so} !== exp) begin
        failures++;
        $display("FAIL random[%0d]: got lat=%0d sum=%h, required lat=%0d sum=%h", i, lat, {co, so}, W, exp);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (oo !== model_ovf(a, b, c)) begin
        failures++;
        $display("FAIL random_ovf[%0d]: got %b, required %b", i, oo, model_ovf(a, b, c));
      end
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] so;
    logic         co, oo;
    int           lat;
    int           bad;
    run_op(8'h12, 8'h34, 1'b1, so, co, oo, lat);
    checks++;
    if (lat !== W || so !== 8'h47 || co !== 1'b0) begin
      failures++;
      $display("FAIL bp_result: got lat=%0d s=%h cout=%b, required %0d 47 0", lat, so, co, W);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0); bus.a = 8'hEE; bus.b = 8'h11; bus.cin = 1'b1;
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.s !== 8'h47 || bus.cout !== 1'b0 || read_ovf() !== oo)
        bad++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d cycles disturbed, required 0", bad);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.s !== 8'h47) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_not_accepted: %0d cycles with activity, required 0", bad);
    end
    $display("backpressure: held s=%h cout=%b, released", so, co);
  endtask

  task automatic test_early_ready();
    logic [W-1:0] so;
    logic         co, oo;
    int           lat;
    bus.out_ready = 1'b1;
    run_op(8'hA5, 8'h5A, 1'b1, so, co, oo, lat);
    checks++;
    if (lat !== W || {co, so} !== model_sum(8'hA5, 8'h5A, 1'b1)) begin
      failures++;
      $display("FAIL early_ready_result: got lat=%0d sum=%h, required %0d %h", lat, {co, so}, W, model_sum(8'hA5, 8'h5A, 1'b1));
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL early_ready_pulse: out_valid=%b one cycle later, required 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
    $display("early_ready: s=%h cout=%b lat=%0d", so, co, lat);
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.in_valid = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses.push_back(i);
    end
    bus.in_valid = 1'b0;
    repeat (2 * W + 6) @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (pulses.size() < 2 || pulses[1] - pulses[0] != W + 2) begin
      failures++;
      $display("FAIL back_to_back_period: %0d pulses, spacing %0d, required spacing %0d",
               pulses.size(), (pulses.size() >= 2) ? pulses[1] - pulses[0] : -1, W + 2);
    end
    checks++;
    if (bus.s !== 8'h30 || bus.cout !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_final: s=%h cout=%b in_ready=%b, required 30 0 1", bus.s, bus.cout, bus.in_ready);
    end
    $display("back_to_back: %0d results, first at %0d", pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] so;
    logic         co, oo;
    int           lat;
    @(negedge clk);
    bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.s !== '0 || bus.cout !== 1'b0 || read_ovf() !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run: out_valid=%b in_ready=%b s=%h cout=%b, required 0 1 00 0",
               bus.out_valid, bus.in_ready, bus.s, bus.cout);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h01, 8'h02, 1'b0, so, co, oo, lat);
    checks++;
    if (lat !== W || so !== 8'h03 || co !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_op: got lat=%0d s=%h cout=%b, required %0d 03 0", lat, so, co, W);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("reset_mid_run: recovered s=%h cout=%b", so, co);
  endtask

  task automatic test_w1();
    int lat;
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus1.a = 1'(i); bus1.b = 1'(i >> 1); bus1.cin = 1'(i >> 2); bus1.in_valid = 1'b1;
      exp = 2'(bus1.a) + 2'(bus1.b) + 2'(bus1.cin);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      $display("w1: a=%b b=%b cin=%b -> s=%b cout=%b lat=%0d", bus1.a, bus1.b, bus1.cin, bus1.s, bus1.cout, lat);
      checks++;
      if (lat !== 1 || {bus1.cout, bus1.s} !== exp) begin
        failures++;
        $display("FAIL w1[%0d]: got lat=%0d sum=%b, required 1 %b", i, lat, {bus1.cout, bus1.s}, exp);
      end
      bus1.out_ready = 1'b1;
      @(negedge clk);
      bus1.out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_early_ready();
    test_back_to_back();
    test_reset_mid_run();
    test_w1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
